// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control tokens, TERC4 table, align FSM states.
// Decode helpers used by tmds_decoder.
package tmds_pkg;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Entry i is the symbol carrying TERC4 nibble i.
  localparam logic [15:0][9:0] TERC4_CODE = {
    10'b1011000011, 10'b0101100011,
    10'b1001110001, 10'b1010001110,
    10'b1011000110, 10'b0110011100,
    10'b0100111001, 10'b1011001100,
    10'b0100111100, 10'b0110001110,
    10'b0100011110, 10'b0101110001,
    10'b1011100010, 10'b1011100100,
    10'b1001100011, 10'b1010011100
  };

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP_HOLD,
    ST_LOCKED
  } align_state_t;

  function automatic logic [7:0] tmds_data(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] r;
    d = q[9] ? ~q[7:0] : q[7:0];
    r[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return r;
  endfunction

  // Returns {hit, c1, c0}.
  function automatic logic [2:0] ctrl_decode(input logic [9:0] q);
    logic [2:0] r;
    case (q)
      CTRL_00: r = 3'b100;
      CTRL_01: r = 3'b101;
      CTRL_10: r = 3'b110;
      CTRL_11: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-alignment FSM: hunts for a run of control tokens, requests
// bit-slips on timeout, and drops lock when tokens stop arriving.
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 4,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16,
  parameter int LOSS_TIMEOUT   = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic is_ctrl,
  output logic locked,
  output logic bitslip,
  output logic hold
);

  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam int LW = $clog2(LOSS_TIMEOUT + 1);

  align_state_t state, state_nx;
  logic [RW-1:0] run_cnt, run_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [LW-1:0] loss_cnt, loss_nx;
  logic slip_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_SEARCH;
      run_cnt  <= '0;
      tmo_cnt  <= '0;
      wait_cnt <= '0;
      loss_cnt <= '0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nx;
      run_cnt  <= run_nx;
      tmo_cnt  <= tmo_nx;
      wait_cnt <= wait_nx;
      loss_cnt <= loss_nx;
      bitslip  <= slip_nx;
      locked   <= (state == ST_LOCKED);
    end
  end

  always_comb begin
    state_nx = state;
    run_nx   = run_cnt;
    tmo_nx   = tmo_cnt;
    wait_nx  = wait_cnt;
    loss_nx  = loss_cnt;
    slip_nx  = 1'b0;
    if (valid) begin
      unique case (state)
        ST_SEARCH: begin
          run_nx = is_ctrl ? run_cnt + RW'(1) : '0;
          tmo_nx = tmo_cnt + TW'(1);
          // A completed token run beats a timeout on the same symbol.
          if (is_ctrl && run_cnt == RW'(CTRL_RUN - 1)) begin
            state_nx = ST_LOCKED;
            run_nx   = '0;
            tmo_nx   = '0;
          end else if (tmo_cnt == TW'(SEARCH_TIMEOUT - 1)) begin
            state_nx = ST_SLIP_HOLD;
            slip_nx  = 1'b1;
            run_nx   = '0;
            tmo_nx   = '0;
          end
        end
        ST_SLIP_HOLD: begin
          wait_nx = wait_cnt + WW'(1);
          if (wait_cnt == WW'(SLIP_WAIT - 1)) begin
            state_nx = ST_SEARCH;
            wait_nx  = '0;
          end
        end
        ST_LOCKED: begin
          loss_nx = is_ctrl ? '0 : loss_cnt + LW'(1);
          if (!is_ctrl && loss_cnt == LW'(LOSS_TIMEOUT - 1)) begin
            state_nx = ST_SEARCH;
            loss_nx  = '0;
          end
        end
        default: state_nx = ST_SEARCH;
      endcase
    end
  end

  assign hold = (state == ST_SLIP_HOLD);

endmodule

// File: rtl/tmds_decoder.sv
// One-channel TMDS receive decoder with word alignment.
// Define TMDS_DECODER_TERC4_EN to add TERC4 (data island) matching.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 4,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16,
  parameter int LOSS_TIMEOUT   = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       out_valid,
  output logic       locked,
  output logic       bitslip,
  output logic [3:0] terc4,
  output logic       terc4_hit
);

  logic [9:0] s1_sym;
  logic       s1_valid;
  logic [2:0] ctrl_dec;
  logic [7:0] data_dec;
  logic       hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sym   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= sym_valid;
      if (sym_valid) s1_sym <= sym_in;
    end
  end

  assign ctrl_dec = ctrl_decode(s1_sym);
  assign data_dec = tmds_data(s1_sym);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      ctrl      <= '0;
      de        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid & ~hold;
      if (s1_valid) begin
        data <= data_dec;
        de   <= ~ctrl_dec[2];
        if (ctrl_dec[2]) ctrl <= ctrl_dec[1:0];
      end
    end
  end

`ifdef TMDS_DECODER_TERC4_EN
  logic       t4_hit;
  logic [3:0] t4_val;

  always_comb begin
    t4_hit = 1'b0;
    t4_val = '0;
    for (int i = 0; i < 16; i++) begin
      if (s1_sym == TERC4_CODE[i]) begin
        t4_hit = 1'b1;
        t4_val = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      terc4     <= '0;
      terc4_hit <= 1'b0;
    end else if (s1_valid) begin
      terc4     <= t4_val;
      terc4_hit <= t4_hit;
    end
  end
`else
  assign terc4     = '0;
  assign terc4_hit = 1'b0;
`endif

  tmds_align_fsm #(
    .CTRL_RUN       (CTRL_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .SLIP_WAIT      (SLIP_WAIT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) u_align (
    .clk     (clk),
    .rst     (rst),
    .valid   (s1_valid),
    .is_ctrl (ctrl_dec[2]),
    .locked  (locked),
    .bitslip (bitslip),
    .hold    (hold)
  );

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed-vector bench for tmds_decoder with shortened timeouts.
// Expected TERC4 results follow TMDS_DECODER_TERC4_EN.
module tb_tmds_decoder;

  localparam logic [9:0] TK01 = 10'b0010101011;
  localparam logic [9:0] TK10 = 10'b0101010100;
`ifdef TMDS_DECODER_TERC4_EN
  localparam bit T4 = 1'b1;
`else
  localparam bit T4 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de, out_valid, locked, bitslip, terc4_hit;
  logic [3:0] terc4;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt, prev, pulses, lock_seen;
  bit v;
  logic [9:0] dtab [4] = '{10'h100, 10'h1FF, 10'h2AC, 10'h0F3};
  int exp_pos [3] = '{64, 132, 200};

  always #5 clk = ~clk;

  tmds_decoder #(
    .CTRL_RUN       (4),
    .SEARCH_TIMEOUT (64),
    .SLIP_WAIT      (4),
    .LOSS_TIMEOUT   (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .data      (data),
    .ctrl      (ctrl),
    .de        (de),
    .out_valid (out_valid),
    .locked    (locked),
    .bitslip   (bitslip),
    .terc4     (terc4),
    .terc4_hit (terc4_hit)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [9:0] s, input logic vl);
    sym_in    = s;
    sym_valid = vl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #5;
    check("rst_data", data, 0);
    check("rst_de", de, 0);
    check("rst_ov", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_slip", bitslip, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // data decode, 2-cycle latency
    cyc(10'h100, 1);
    cyc(10'h1FF, 1);
    check("d100_data", data, 8'h00);
    check("d100_de", de, 1);
    check("d100_ov", out_valid, 1);
    cyc(10'h000, 0);
    check("d1ff_data", data, 8'h01);
    check("d1ff_de", de, 1);
    cyc(10'h000, 0);
    check("idle_ov", out_valid, 0);
    check("idle_data_hold", data, 8'h01);

    // lock on 4 tokens
    repeat (4) cyc(TK10, 1);
    cyc(10'h000, 0);
    check("tok_de", de, 0);
    check("tok_ctrl", ctrl, 2'b10);
    check("lock_not_yet", locked, 0);
    cyc(10'h000, 0);
    check("lock_set", locked, 1);

    // loss of lock
    for (int i = 0; i < 30; i++) cyc(10'h100, 1);
    cyc(TK01, 1);
    cyc(10'h1FF, 1);
    check("tok01_de", de, 0);
    check("tok01_ctrl", ctrl, 2'b01);
    for (int i = 0; i < 30; i++) cyc(10'h1FF, 1);
    cyc(10'h000, 0);
    cyc(10'h000, 0);
    check("loss31_locked", locked, 1);
    check("ctrl_held", ctrl, 2'b01);
    check("ctrl_held_de", de, 1);
    cyc(10'h100, 1);
    cyc(10'h000, 0);
    cyc(10'h000, 0);
    check("loss32_locked", locked, 0);

    // reset mid-lock
    repeat (4) cyc(TK10, 1);
    cyc(10'h000, 0);
    cyc(10'h000, 0);
    check("relock", locked, 1);
    rst = 1'b1;
    #1;
    check("arst_locked", locked, 0);
    check("arst_ctrl", ctrl, 0);
    check("arst_data", data, 0);
    check("arst_de", de, 0);
    check("arst_terc4", terc4, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // bit-slip period over valid symbols only, with idle gaps
    vcnt = 0;
    pulses = 0;
    lock_seen = 0;
    for (int c = 0; c < 260; c++) begin
      prev = vcnt;
      v = (c % 7) != 3;
      cyc(dtab[c % 4], v);
      if (v) vcnt++;
      if (bitslip) begin
        if (pulses < 3) check("slip_pos", prev, exp_pos[pulses]);
        pulses++;
      end
      if (locked) lock_seen++;
    end
    check("slip_count", pulses, 3);
    check("slip_no_lock", lock_seen, 0);

    // TERC4
    do_reset();
    cyc(10'b1010011100, 1);
    cyc(10'b0100011110, 1);
    check("t4_0_hit", terc4_hit, T4);
    check("t4_0_val", terc4, 0);
    check("t4_0_de", de, 1);
    cyc(10'h100, 1);
    check("t4_5_hit", terc4_hit, T4);
    check("t4_5_val", terc4, T4 ? 4'h5 : 4'h0);
    cyc(10'h000, 0);
    check("t4_none_hit", terc4_hit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
